// File: rtl/seq_pkg.sv
// Shared definitions for the sequence_tx serial frame transmitter.
package seq_pkg;

  // Frame phases. The FSM register holds the raw encodings below.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PREAMBLE = 3'd1,
    PAYLOAD  = 3'd2,
    PARITY   = 3'd3,
    GAP      = 3'd4
  } seq_state_e;

  localparam logic [2:0] ST_IDLE     = IDLE;
  localparam logic [2:0] ST_PREAMBLE = PREAMBLE;
  localparam logic [2:0] ST_PAYLOAD  = PAYLOAD;
  localparam logic [2:0] ST_PARITY   = PARITY;
  localparam logic [2:0] ST_GAP      = GAP;

  // Line sync pattern that downstream preamble detectors align on.
  localparam logic [3:0] SEQ_PREAMBLE = 4'b1101;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seq_tx_shifter.sv
// MSB-first parallel-load shift register with a bits-remaining down-counter.
// bit_out is the current line bit; last is high while the final bit of the
// loaded segment is on the line.
module seq_tx_shifter #(
  parameter int W  = 8,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [W-1:0]  load_data,
  input  logic [CW-1:0] load_count,
  input  logic          shift,
  output logic          bit_out,
  output logic          last
);

  logic [W-1:0]  sreg;
  logic [CW-1:0] cnt;

  // Load takes priority over shift; counter saturates at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (load) begin
      sreg <= load_data;
      cnt  <= load_count;
    end else if (shift) begin
      sreg <= sreg << 1;
      if (cnt != '0) cnt <= cnt - CW'(1);
    end
  end

  assign bit_out = sreg[W-1];
  assign last    = (cnt == '0);

endmodule

// File: rtl/sequence_tx.sv
// Serial frame transmitter: preamble, payload (and optional even parity bit),
// one bit per clock, followed by a forced idle gap.
// Optional feature: define SEQUENCE_TX_PARITY_EN to append ^payload after the payload.
// The line bit comes straight from the shifter MSB flop; the shifter is cleared
// whenever no frame bit is on the line, so the line reads 0 while vld is low.
module sequence_tx
  import seq_pkg::*;
#(
  parameter int                   PATTERN_W  = 4,
  parameter logic [PATTERN_W-1:0] PATTERN    = SEQ_PREAMBLE,
  parameter int                   DATA_W     = 8,
  parameter int                   GAP_CYCLES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_tx_valid,
  input  logic [DATA_W-1:0] i_tx_data,
  output logic              o_tx_ready,
  output logic              o_sequence_out,
  output logic              o_sequence_vld,
  output logic              o_busy,
  output logic              o_done
);

  localparam int SW       = max2(PATTERN_W, DATA_W);
  localparam int CW       = $clog2(SW + 1);
  localparam int GW       = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  logic [2:0]        state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic              vld_q, vld_d;
  logic              done_q, done_d;
  logic              finish;

  logic              sh_load, sh_shift, sh_bit, sh_last;
  logic [SW-1:0]     sh_data;
  logic [CW-1:0]     sh_count;

`ifdef SEQUENCE_TX_PARITY_EN
  logic parity_bit;
  assign parity_bit = ^data_q;
`endif

  seq_tx_shifter #(
    .W  (SW),
    .CW (CW)
  ) u_shifter (
    .clk        (i_clk),
    .rst_n      (i_rst_n),
    .load       (sh_load),
    .load_data  (sh_data),
    .load_count (sh_count),
    .shift      (sh_shift),
    .bit_out    (sh_bit),
    .last       (sh_last)
  );

  // Next-state: segments are loaded left-aligned so the first bit sits at the MSB.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    gap_d    = gap_q;
    vld_d    = vld_q;
    done_d   = 1'b0;
    finish   = 1'b0;
    sh_load  = 1'b0;
    sh_shift = 1'b0;
    sh_data  = '0;
    sh_count = '0;
    case (state_q)
      ST_IDLE: begin
        vld_d = 1'b0;
        if (i_tx_valid) begin
          data_d   = i_tx_data;
          sh_load  = 1'b1;
          sh_data  = SW'(PATTERN) << (SW - PATTERN_W);
          sh_count = CW'(PATTERN_W - 1);
          vld_d    = 1'b1;
          state_d  = ST_PREAMBLE;
        end
      end
      ST_PREAMBLE: begin
        if (sh_last) begin
          sh_load  = 1'b1;
          sh_data  = SW'(data_q) << (SW - DATA_W);
          sh_count = CW'(DATA_W - 1);
          state_d  = ST_PAYLOAD;
        end else begin
          sh_shift = 1'b1;
        end
      end
      ST_PAYLOAD: begin
        if (sh_last) begin
`ifdef SEQUENCE_TX_PARITY_EN
          sh_load  = 1'b1;
          sh_data  = SW'(parity_bit) << (SW - 1);
          sh_count = '0;
          state_d  = ST_PARITY;
`else
          finish   = 1'b1;
`endif
        end else begin
          sh_shift = 1'b1;
        end
      end
`ifdef SEQUENCE_TX_PARITY_EN
      ST_PARITY: finish = 1'b1;
`endif
      ST_GAP: begin
        if (gap_q == '0) state_d = ST_IDLE;
        else             gap_d   = gap_q - GW'(1);
      end
      default: begin
        // Unreachable encodings recover to a clean idle line.
        state_d = ST_IDLE;
        vld_d   = 1'b0;
        sh_load = 1'b1;
      end
    endcase

    if (finish) begin
      sh_load = 1'b1;
      sh_data = '0;
      vld_d   = 1'b0;
      done_d  = 1'b1;
      if (GAP_CYCLES == 0) begin
        state_d = ST_IDLE;
      end else begin
        state_d = ST_GAP;
        gap_d   = GW'(GAP_LAST);
      end
    end
  end

  // State and output registers; reset abandons any frame without a done pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      gap_q   <= '0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      gap_q   <= gap_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
    end
  end

  assign o_tx_ready     = (state_q == ST_IDLE);
  assign o_busy         = (state_q != ST_IDLE);
  assign o_sequence_out = sh_bit;
  assign o_sequence_vld = vld_q;
  assign o_done         = done_q;

endmodule

// File: tb/tb_sequence_tx.sv
// Self-checking bench for sequence_tx: one instance with a 2-cycle gap and one
// with no gap, both compared every cycle against a timeline model that derives
// each output from the number of edges since the word was accepted.
module tb_sequence_tx;

  localparam int PW = 4;
  localparam int DW = 8;
`ifdef SEQUENCE_TX_PARITY_EN
  localparam int FB = PW + DW + 1;
`else
  localparam int FB = PW + DW;
`endif
  localparam logic [PW-1:0] PAT = 4'b1101;
  localparam int IDLE_T = 1000;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       valid [2];
  logic [7:0] data  [2];
  logic       ready [2];
  logic       sout  [2];
  logic       svld  [2];
  logic       busy  [2];
  logic       done  [2];

  int n_cmp = 0;
  int n_bad = 0;
  bit checking  = 1'b0;
  bit rand_mode = 1'b0;

  // Model: t = edges since accept (IDLE_T when nothing in flight).
  int            t [2] = '{IDLE_T, IDLE_T};
  logic [FB-1:0] frame [2];
  logic [7:0]    wq0[$];
  logic [7:0]    wq1[$];

  always #5 clk = ~clk;

  sequence_tx #(.PATTERN_W(PW), .PATTERN(PAT), .DATA_W(DW), .GAP_CYCLES(2)) dut_gap2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_tx_valid(valid[0]), .i_tx_data(data[0]),
    .o_tx_ready(ready[0]), .o_sequence_out(sout[0]), .o_sequence_vld(svld[0]),
    .o_busy(busy[0]), .o_done(done[0])
  );

  sequence_tx #(.PATTERN_W(PW), .PATTERN(PAT), .DATA_W(DW), .GAP_CYCLES(0)) dut_gap0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_tx_valid(valid[1]), .i_tx_data(data[1]),
    .o_tx_ready(ready[1]), .o_sequence_out(sout[1]), .o_sequence_vld(svld[1]),
    .o_busy(busy[1]), .o_done(done[1])
  );

  function automatic int gap_of(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  function automatic logic [FB-1:0] make_frame(input logic [7:0] d);
`ifdef SEQUENCE_TX_PARITY_EN
    return {PAT, d, ^d};
`else
    return {PAT, d};
`endif
  endfunction

  function automatic logic exp_ready(input int i);
    return t[i] > FB + gap_of(i);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic check_outputs();
    for (int i = 0; i < 2; i++) begin
      logic e_vld;
      logic e_bit;
      e_vld = (t[i] <= FB);
      e_bit = e_vld ? frame[i][FB - t[i]] : 1'b0;
      check_eq($sformatf("d%0d_vld", i),   32'(svld[i]),  32'(e_vld));
      check_eq($sformatf("d%0d_line", i),  32'(sout[i]),  32'(e_bit));
      check_eq($sformatf("d%0d_done", i),  32'(done[i]),  32'(t[i] == FB + 1));
      check_eq($sformatf("d%0d_busy", i),  32'(busy[i]),  32'(!exp_ready(i)));
      check_eq($sformatf("d%0d_ready", i), 32'(ready[i]), 32'(exp_ready(i)));
    end
  endtask

  // Model update: accept when valid meets a modelled-ready cycle.
  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        t[i] <= IDLE_T;
      end else if (valid[i] && exp_ready(i)) begin
        t[i]     <= 1;
        frame[i] <= make_frame(data[i]);
      end else if (t[i] < IDLE_T) begin
        t[i] <= t[i] + 1;
      end
    end
  end

  task automatic drive_inputs();
    if (t[0] == 1 && wq0.size() != 0) void'(wq0.pop_front());
    if (t[1] == 1 && wq1.size() != 0) void'(wq1.pop_front());
    if (wq0.size() != 0) begin
      data[0]  = wq0[0];
      valid[0] = !rand_mode || ($urandom_range(3) != 0);
    end else begin
      data[0]  = 8'($urandom);
      valid[0] = 1'b0;
    end
    if (wq1.size() != 0) begin
      data[1]  = wq1[0];
      valid[1] = !rand_mode || ($urandom_range(3) != 0);
    end else begin
      data[1]  = 8'($urandom);
      valid[1] = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (checking) check_outputs();
    drive_inputs();
  end

  task automatic wait_drained(input int budget);
    int k;
    k = 0;
    while (!(wq0.size() == 0 && wq1.size() == 0 && exp_ready(0) && exp_ready(1))
           && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    check_eq("drain_in_budget", 32'(k < budget), 32'd1);
  endtask

  initial begin
    int k;
    valid[0] = 1'b0; valid[1] = 1'b0;
    data[0]  = 8'h00; data[1]  = 8'h00;
    #1 rst_n = 1'b0;
    checking = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    #1;
    check_eq("post_reset_ready", 32'(ready[0]), 32'd1);
    check_eq("post_reset_busy",  32'(busy[0]),  32'd0);

    // Directed words; valid held so back-to-back frames wait for ready.
    wq0.push_back(8'hA5); wq0.push_back(8'h07); wq0.push_back(8'h01); wq0.push_back(8'h02);
    wq1.push_back(8'hA5); wq1.push_back(8'h01); wq1.push_back(8'h02);
    wait_drained(200);

    // Asynchronous reset in payload bit 3.
    wq0.push_back(8'h5A);
    k = 0;
    while (t[0] != PW + 4 && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    check_eq("reach_payload_bit3", 32'(t[0] == PW + 4), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_vld",   32'(svld[0]),  32'd0);
    check_eq("async_rst_line",  32'(sout[0]),  32'd0);
    check_eq("async_rst_done",  32'(done[0]),  32'd0);
    check_eq("async_rst_busy",  32'(busy[0]),  32'd0);
    check_eq("async_rst_ready", 32'(ready[0]), 32'd1);
    @(negedge clk);
    @(negedge clk);
    #3 rst_n = 1'b1;
    wq0.delete();
    wq0.push_back(8'h3C);
    wq1.push_back(8'hC3);
    wait_drained(100);

    // Randomized traffic with valid dropping out while a word is pending.
    rand_mode = 1'b1;
    repeat (600) begin
      @(posedge clk);
      #1;
      if (wq0.size() < 2 && $urandom_range(3) == 0) wq0.push_back(8'($urandom));
      if (wq1.size() < 2 && $urandom_range(3) == 0) wq1.push_back(8'($urandom));
    end
    wait_drained(300);

    checking = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
